// File: rtl/div_seq_if.sv
// ----------------------------------------------------------------------------
// div_seq_if : decode/execute handshake bundle for the sequential divider
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface div_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;
  logic            illegal;

  modport master (
    output start, op, dividend, divisor, flush,
    input  busy, stall, done, result, illegal
  );

  modport slave (
    input  start, op, dividend, divisor, flush,
    output busy, stall, done, result, illegal
  );
endinterface

`default_nettype wire

// File: rtl/div_seq.sv
// ----------------------------------------------------------------------------
// div_seq : RV32M radix-2 restoring DIV/DIVU/REM/REMU sequencer
// Optional feature macro: DIV_SEQ_REM_EN (REM/REMU support).   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module div_seq #(
  parameter int XLEN = 32
) (
  input wire logic    clk,
  input wire logic    rst_n,
  div_seq_if.slave    bus
);

  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_PREP = 3'd1;
  localparam logic [2:0] c_ITER = 3'd2;
  localparam logic [2:0] c_FIX  = 3'd3;
  localparam logic [2:0] c_DONE = 3'd4;

  localparam logic [XLEN-1:0] c_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [2:0]      state_q,  state_d;
  logic [XLEN-1:0] quo_q,    quo_d;
  logic [XLEN-1:0] rem_q,    rem_d;
  logic [XLEN-1:0] dabs_q,   dabs_d;
  logic [CW-1:0]   cnt_q,    cnt_d;
  logic            sgn_q,    sgn_d;
  logic            qneg_q,   qneg_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            busy_q,   busy_d;
  logic            done_q,   done_d;
  logic            illegal_q, illegal_d;
`ifdef DIV_SEQ_REM_EN
  logic            rsel_q,   rsel_d;
  logic            rneg_q,   rneg_d;
`endif

  logic            w_legal;
  logic            w_dvd_neg;
  logic            w_dvs_neg;
  logic [XLEN-1:0] w_dvd_abs;
  logic [XLEN-1:0] w_dvs_abs;
  logic            w_ovf;
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN:0]   w_trial;
  logic [XLEN-1:0] w_quo_fix;

`ifdef DIV_SEQ_REM_EN
  assign w_legal = 1'b1;
`else
  assign w_legal = ~bus.op[1];
`endif

  // In PREP quo_q/dabs_q still hold the raw operands latched at accept.
  assign w_dvd_neg = sgn_q & quo_q[XLEN-1];
  assign w_dvs_neg = sgn_q & dabs_q[XLEN-1];
  assign w_dvd_abs = w_dvd_neg ? -quo_q  : quo_q;
  assign w_dvs_abs = w_dvs_neg ? -dabs_q : dabs_q;
  assign w_ovf     = sgn_q & (quo_q == c_MIN) & (dabs_q == '1);

  assign w_rem_sh  = {rem_q, quo_q[XLEN-1]};
  assign w_trial   = w_rem_sh - {1'b0, dabs_q};
  assign w_quo_fix = qneg_q ? -quo_q : quo_q;

  always_comb begin
    state_d  = state_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dabs_d   = dabs_q;
    cnt_d    = cnt_q;
    sgn_d    = sgn_q;
    qneg_d   = qneg_q;
    result_d = result_q;
`ifdef DIV_SEQ_REM_EN
    rsel_d   = rsel_q;
    rneg_d   = rneg_q;
`endif
    case (state_q)
      c_IDLE: begin
        if (bus.start && w_legal) begin
          state_d = c_PREP;
          quo_d   = bus.dividend;
          dabs_d  = bus.divisor;
          sgn_d   = ~bus.op[0];
`ifdef DIV_SEQ_REM_EN
          rsel_d  = bus.op[1];
`endif
        end
      end
      c_PREP: begin
        quo_d  = w_dvd_abs;
        rem_d  = '0;
        dabs_d = w_dvs_abs;
        cnt_d  = CW'(XLEN-1);
        qneg_d = w_dvd_neg ^ w_dvs_neg;
`ifdef DIV_SEQ_REM_EN
        rneg_d = w_dvd_neg;
`endif
        if (dabs_q == '0) begin
          state_d = c_DONE;
`ifdef DIV_SEQ_REM_EN
          result_d = rsel_q ? quo_q : '1;
`else
          result_d = '1;
`endif
        end else if (w_ovf) begin
          state_d = c_DONE;
`ifdef DIV_SEQ_REM_EN
          result_d = rsel_q ? '0 : c_MIN;
`else
          result_d = c_MIN;
`endif
        end else begin
          state_d = c_ITER;
        end
      end
      c_ITER: begin
        if (!w_trial[XLEN]) begin
          rem_d = w_trial[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = w_rem_sh[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = c_FIX;
      end
      c_FIX: begin
        state_d = c_DONE;
`ifdef DIV_SEQ_REM_EN
        result_d = rsel_q ? (rneg_q ? -rem_q : rem_q) : w_quo_fix;
`else
        result_d = w_quo_fix;
`endif
      end
      c_DONE:  state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase

    // Flush aborts silently and must not disturb the last delivered result.
    if (bus.flush) begin
      state_d  = c_IDLE;
      result_d = result_q;
    end
  end

  assign busy_d    = (state_d == c_PREP) || (state_d == c_ITER) || (state_d == c_FIX);
  assign done_d    = (state_d == c_DONE);
  assign illegal_d = (state_q == c_IDLE) && bus.start && !w_legal && !bus.flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= c_IDLE;
      quo_q     <= '0;
      rem_q     <= '0;
      dabs_q    <= '0;
      cnt_q     <= '0;
      sgn_q     <= 1'b0;
      qneg_q    <= 1'b0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef DIV_SEQ_REM_EN
      rsel_q    <= 1'b0;
      rneg_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dabs_q    <= dabs_d;
      cnt_q     <= cnt_d;
      sgn_q     <= sgn_d;
      qneg_q    <= qneg_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
`ifdef DIV_SEQ_REM_EN
      rsel_q    <= rsel_d;
      rneg_q    <= rneg_d;
`endif
    end
  end

  assign bus.busy    = busy_q;
  assign bus.stall   = (bus.start && (state_q == c_IDLE) && w_legal) || busy_q;
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.illegal = illegal_q;

endmodule

`default_nettype wire
